// File: rtl/feeder_pkg.sv
// rtl/feeder_pkg.sv - shared types and constants for the systolic skew feeder
// Contents:
//   state_t    : feeder FSM state (IDLE, STREAM, FLUSH, DONE)
//   LANE_W     : default operand (lane slice) width in bits
//   flush_len  : number of zero cycles needed to drain the array edge
package feeder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_FLUSH  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam int LANE_W = 16;

   // The deepest lane adds ROWS-1 (or COLS-1) cycles of skew, and the
   // wavefront still has to cross the array, so drain for ROWS+COLS cycles.
   function automatic int flush_len(input int rows, input int cols);
      return rows + cols;
   endfunction

endpackage

// File: rtl/skew_delay_line.sv
// rtl/skew_delay_line.sv - fixed-depth register delay line for one array lane
// Ports:
//   clk   : clock, shifts on every rising edge
//   rst_n : asynchronous active-low reset, clears every stage
//   d     : value entering stage 0
//   q     : value leaving the last stage (DEPTH cycles after entry)
module skew_delay_line #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stg [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            stg[k] <= '0;
         end
      end else begin
         stg[0] <= d;
         for (int k = 1; k < DEPTH; k++) begin
            stg[k] <= stg[k-1];
         end
      end
   end

   assign q = stg[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// rtl/systolic_skew_feeder.sv - skews A/B beat vectors onto the systolic array edge
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   in_valid/ready   : beat handshake; in_last marks the final beat of a job
//   in_a, in_b       : A column vector (ROWS lanes), B row vector (COLS lanes)
//   a_out, b_out     : skewed lanes; lane i delayed i extra cycles, zero when idle
//   busy, done       : job in progress / one-cycle pulse after the drain
//   beat_count       : beats accepted in the current or most recent job (saturating)
module systolic_skew_feeder
   import feeder_pkg::*;
#(
   parameter int N     = LANE_W,
   parameter int ROWS  = 4,
   parameter int COLS  = 4,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [ROWS*N-1:0] in_a,
   input  logic [COLS*N-1:0] in_b,
   output logic [ROWS*N-1:0] a_out,
   output logic [COLS*N-1:0] b_out,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  beat_count
);

   localparam int FLUSH_LEN = flush_len(ROWS, COLS);
   localparam int FW        = (FLUSH_LEN > 2) ? $clog2(FLUSH_LEN) : 1;
   localparam logic [FW-1:0]    FLUSH_LOAD = FW'(FLUSH_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;

   state_t            state;
   logic [FW-1:0]     flush_cnt;
   logic              accept;
   logic [ROWS*N-1:0] a_in0;
   logic [COLS*N-1:0] b_in0;

   assign in_ready = (state == ST_IDLE) || (state == ST_STREAM);
   assign accept   = in_valid && in_ready;
   assign busy     = (state != ST_IDLE);
   assign done     = (state == ST_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         flush_cnt  <= '0;
         beat_count <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_STREAM: begin
               if (accept) begin
                  // First beat of a job restarts the count; later beats saturate.
                  if (state == ST_IDLE) begin
                     beat_count <= CNT_W'(1);
                  end else if (beat_count != CNT_MAX) begin
                     beat_count <= beat_count + 1'b1;
                  end
                  if (in_last) begin
                     state     <= ST_FLUSH;
                     flush_cnt <= FLUSH_LOAD;
                  end else begin
                     state <= ST_STREAM;
                  end
               end
            end
            ST_FLUSH: begin
               if (flush_cnt == '0) begin
                  state <= ST_DONE;
               end else begin
                  flush_cnt <= flush_cnt - 1'b1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Cycles without an accepted beat inject zero bubbles into every lane.
   assign a_in0 = accept ? in_a : '0;
   assign b_in0 = accept ? in_b : '0;

   for (genvar gi = 0; gi < ROWS; gi++) begin : g_a_lane
      skew_delay_line #(.WIDTH(N), .DEPTH(1 + gi)) u_dl (
         .clk   (clk),
         .rst_n (rst_n),
         .d     (a_in0[gi*N +: N]),
         .q     (a_out[gi*N +: N])
      );
   end

   for (genvar gj = 0; gj < COLS; gj++) begin : g_b_lane
      skew_delay_line #(.WIDTH(N), .DEPTH(1 + gj)) u_dl (
         .clk   (clk),
         .rst_n (rst_n),
         .d     (b_in0[gj*N +: N]),
         .q     (b_out[gj*N +: N])
      );
   end

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
Transmit side of the systolic MAC array interface. It accepts one job as a stream of beats; each beat holds a full column vector of A operands and a full row vector of B operands. It drives the array edge with the staggered timing the processing elements need: lane i is delayed i extra cycles, and lanes carry zero whenever no data is present. After the last beat it flushes zeros through the array for ROWS+COLS cycles, then signals done.

Parameters:
N, 16, operand width in bits (matches the PE data width)
ROWS, 4, number of A lanes (array rows)
COLS, 4, number of B lanes (array columns)
CNT_W, 16, width of beat_count

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  beat offered
in_ready  output  1  feeder can accept a beat
in_last  input  1  offered beat is the last of the job; sampled only when in_valid is high
in_a  input  ROWS*N  A vector; lane i is in_a[i*N +: N]
in_b  input  COLS*N  B vector; lane j is in_b[j*N +: N]
a_out  output  ROWS*N  skewed A to the array row inputs; lane i is a_out[i*N +: N]
b_out  output  COLS*N  skewed B to the array column inputs
busy  output  1  state is not IDLE
done  output  1  one-cycle pulse when the job is fully drained
beat_count  output  CNT_W  beats accepted in the current or most recent job

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, flush counter = 0, beat_count = 0.
  - All delay-line stages = 0, so a_out = 0 and b_out = 0.
  - in_ready = 1, busy = 0, done = 0.
- Acceptance: a beat is accepted on an edge where in_valid && in_ready. in_ready = 1 in IDLE and STREAM, 0 in FLUSH and DONE.
- Delay lines:
  - Shift every cycle in every state.
  - Stage 0 loads the accepted lane value, or 0 when nothing is accepted (bubble).
  - A lane i has 1+i register stages. B lane j has 1+j register stages.
  - A beat accepted at edge E appears on lane i after edge E+i. Lane 0 is visible the cycle after acceptance.
  - Values pass through bit-exact; no arithmetic or saturation in this block.
- FSM states: IDLE, STREAM, FLUSH, DONE.
  - IDLE, accept with in_last = 0 -> STREAM; beat_count = 1.
  - IDLE, accept with in_last = 1 -> FLUSH; beat_count = 1; flush counter = ROWS+COLS-1.
  - STREAM, accept with in_last = 0 -> STREAM; beat_count + 1, saturating at 2^CNT_W-1.
  - STREAM, accept with in_last = 1 -> FLUSH; increment beat_count; flush counter = ROWS+COLS-1.
  - STREAM, no accept -> stay in STREAM; a zero bubble enters the lanes.
  - FLUSH: decrement the counter each cycle. On the edge where the counter is 0 -> DONE. FLUSH therefore lasts exactly ROWS+COLS cycles.
  - DONE -> IDLE unconditionally after one cycle.
- Outputs decoded from the registered state: done = (state == DONE), busy = (state != IDLE).
- beat_count holds its value after done until the first accept of the next job.
- in_last with in_valid low is ignored.
- in_valid held high during FLUSH/DONE is not accepted; the beat is taken in the first IDLE cycle.
- Reset mid-job aborts immediately: all lanes go to zero and nothing is held over.

Decomposition:
- Shared package feeder_pkg holds:
  - the state enum type;
  - the lane-slice width constant;
  - a function returning flush length (ROWS+COLS).
- One sub-module skew_delay_line (parameters WIDTH, DEPTH; clk, rst_n, d, q). Instantiated per lane with generate: A lane i uses DEPTH = 1+i, B lane j uses DEPTH = 1+j.

Test Plan (ROWS=2, COLS=2, N=16 unless stated):
1. rst_n low mid-simulation -> a_out = 0, b_out = 0, in_ready = 1, busy = 0, done = 0, beat_count = 0, all asynchronously without a clock edge.
2. Single-beat job at edge E0: in_a = {0x0800, 0x0400}, in_b = {0x0C00, 0x0400}, in_last = 1.
   - After E0: a lane0 = 0x0400, b lane0 = 0x0400.
   - After E0+1: a lane1 = 0x0800, b lane1 = 0x0C00; all lanes return to 0 afterwards.
   - in_ready = 0 from after E0 through after E0+4.
   - done = 1 only in the cycle after E0+4; in_ready = 1 after E0+5; beat_count = 1.
3. Three-beat job with in_valid low for one cycle between beats 1 and 2 -> exactly one zero slot on each lane between beat values, skewed per lane; beat_count = 3; done 4 cycles after the last accept.
4. in_valid held high with a new beat during FLUSH -> no acceptance and no lane change from that beat; beat accepted in the first IDLE cycle after done; beat_count restarts at 1.
5. rst_n pulsed low while a 4-beat job is in STREAM -> outputs zero, no done pulse ever issued; a fresh job afterwards behaves as in scenario 2.
6. CNT_W = 2, 5-beat job -> beat_count reads 1, 2, 3, 3, 3 (saturates); FLUSH still 4 cycles.
